// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes (funct3) and FSM states.
package lsu_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } lsu_state_e;

    // True for the five funct3 values the unit understands.
    function automatic logic size_legal(input logic [2:0] size);
        return (size == SZ_B) || (size == SZ_H) || (size == SZ_W) ||
               (size == SZ_BU) || (size == SZ_HU);
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Lane steering for the load/store unit: extracts and extends the addressed
// byte/half of a memory word for loads, and merges store data into that word.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  size,
    input  logic [31:0] store_data,
    output logic [31:0] load_value,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lanes and extend according to the load size.
    always_comb begin
        byte_sel = word[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_B:    load_value = {{24{byte_sel[7]}}, byte_sel};
            SZ_BU:   load_value = {24'h000000, byte_sel};
            SZ_H:    load_value = {{16{half_sel[15]}}, half_sel};
            SZ_HU:   load_value = {16'h0000, half_sel};
            default: load_value = word;
        endcase
    end

    // Replace only the addressed lane(s); every other byte keeps the read value.
    always_comb begin
        merged_word = word;
        case (size)
            SZ_B, SZ_BU: merged_word[{offset, 3'b000} +: 8] = store_data[7:0];
            SZ_H, SZ_HU: begin
                if (offset[1]) begin
                    merged_word[31:16] = store_data[15:0];
                end else begin
                    merged_word[15:0] = store_data[15:0];
                end
            end
            default:     merged_word = store_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word core requests into word-aligned accesses
// on an async-read, sync-write data memory. Sub-word stores are read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        fault_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i
);

    lsu_state_e  state_q;
    logic [1:0]  offset_q;
    logic [2:0]  size_q;
    logic        we_q;
    logic [31:0] wd_q;
    logic        mem_we_q;

    logic        misaligned;
    logic        out_of_range;
    logic        req_bad;
    logic [31:0] load_value;
    logic [31:0] merged_word;

    // Request check, only meaningful while IDLE.
    always_comb begin
        misaligned = 1'b0;
        if ((core_size_i == SZ_H) || (core_size_i == SZ_HU)) begin
            misaligned = core_addr_i[0];
        end else if (core_size_i == SZ_W) begin
            misaligned = (core_addr_i[1:0] != 2'b00);
        end
        out_of_range = (core_addr_i >= 32'(MEM_BYTES));
        req_bad      = misaligned || out_of_range || !size_legal(core_size_i);
    end

    // Stall while an access is in flight; a faulting request retires immediately.
    always_comb begin
        core_stall_o = core_req_i && (state_q != RESP) && !((state_q == IDLE) && req_bad);
    end

    // Gating with reset keeps a reset that lands in WRITE from committing the store.
    always_comb begin
        mem_we_o = mem_we_q && rst_n;
    end

    lsu_byte_lane u_byte_lane (
        .word        (mem_rd_i),
        .offset      (offset_q),
        .size        (size_q),
        .store_data  (wd_q),
        .load_value  (load_value),
        .merged_word (merged_word)
    );

    // Access FSM with registered memory-side and core-side outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            offset_q   <= 2'b00;
            size_q     <= 3'b000;
            we_q       <= 1'b0;
            wd_q       <= 32'h0;
            mem_we_q   <= 1'b0;
            core_rd_o  <= 32'h0;
            mem_addr_o <= 32'h0;
            mem_wd_o   <= 32'h0;
            fault_o    <= 1'b0;
        end else begin
            fault_o  <= 1'b0;
            mem_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (core_req_i) begin
                        if (req_bad) begin
                            fault_o <= 1'b1;
                        end else begin
                            offset_q   <= core_addr_i[1:0];
                            size_q     <= core_size_i;
                            we_q       <= core_we_i;
                            wd_q       <= core_wd_i;
                            mem_addr_o <= {core_addr_i[31:2], 2'b00};
                            if (core_we_i && (core_size_i == SZ_W)) begin
                                mem_wd_o <= core_wd_i;
                                mem_we_q <= 1'b1;
                                state_q  <= WRITE;
                            end else begin
                                state_q <= READ;
                            end
                        end
                    end
                end
                READ: begin
                    if (we_q) begin
                        mem_wd_o <= merged_word;
                        mem_we_q <= 1'b1;
                        state_q  <= WRITE;
                    end else begin
                        core_rd_o <= load_value;
                        state_q   <= RESP;
                    end
                end
                WRITE:   state_q <= RESP;
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small behavioural data memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        core_req_i = 1'b0;
    logic        core_we_i = 1'b0;
    logic [2:0]  core_size_i = 3'b000;
    logic [31:0] core_addr_i = 32'h0;
    logic [31:0] core_wd_i = 32'h0;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        fault_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;

    logic [31:0] mem [256];

    int checks = 0;
    int failures = 0;

    load_store_unit #(.MEM_BYTES(1024)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_size_i  (core_size_i),
        .core_addr_i  (core_addr_i),
        .core_wd_i    (core_wd_i),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
        .fault_o      (fault_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wd_o     (mem_wd_o),
        .mem_rd_i     (mem_rd_i)
    );

    always #5 clk = ~clk;

    assign mem_rd_i = mem[mem_addr_o[9:2]];

    always @(posedge clk) begin
        if (mem_we_o) mem[mem_addr_o[9:2]] <= mem_wd_o;
    end

    // Present a request at a falling edge and follow it until the stall drops.
    // Returns in the retire cycle with the request still applied.
    task automatic do_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                             input logic [31:0] wd, input logic scramble,
                             output int stalls, output int we_pulses,
                             output logic [31:0] wd_seen, output logic [31:0] addr_seen);
        @(negedge clk);
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = size;
        core_addr_i = addr;
        core_wd_i   = wd;
        stalls      = 0;
        we_pulses   = 0;
        wd_seen     = 32'h0;
        addr_seen   = 32'h0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (mem_we_o) begin
                we_pulses++;
                wd_seen   = mem_wd_o;
                addr_seen = mem_addr_o;
            end
            if (!core_stall_o) break;
            stalls++;
            @(negedge clk);
            if (scramble) begin
                core_addr_i = 32'hFFFF_FFFF;
                core_wd_i   = 32'hDEAD_BEEF;
            end
        end
    endtask

    task automatic idle_cycle(output logic fault_seen, output logic we_seen);
        @(negedge clk);
        core_req_i = 1'b0;
        #1;
        fault_seen = fault_o;
        we_seen    = mem_we_o;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        core_req_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (core_rd_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_rd: got %h want %h", core_rd_o, 32'h0);
        end
        checks++;
        if ({mem_we_o, fault_o, core_stall_o} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctrl: we/fault/stall got %b want 000",
                     {mem_we_o, fault_o, core_stall_o});
        end
        checks++;
        if ({mem_addr_o, mem_wd_o} !== 64'h0) begin
            failures++;
            $display("FAIL reset_mem: addr %h wd %h want 0", mem_addr_o, mem_wd_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_byte;
        int st, wp;
        logic [31:0] wds, ads;
        logic fs, ws;
        // Address scrambled after acceptance must not matter.
        do_access(1'b0, 3'b000, 32'h41, 32'h0, 1'b1, st, wp, wds, ads);
        checks++;
        if (core_rd_o !== 32'hFFFF_FFAA) begin
            failures++;
            $display("FAIL lb_data: got %h want %h", core_rd_o, 32'hFFFF_FFAA);
        end
        checks++;
        if (st != 2) begin
            failures++;
            $display("FAIL lb_stall: got %0d want 2", st);
        end
        checks++;
        if (wp != 0) begin
            failures++;
            $display("FAIL lb_no_write: got %0d pulses want 0", wp);
        end
        idle_cycle(fs, ws);
    endtask

    task automatic test_load_half;
        int st, wp;
        logic [31:0] wds, ads;
        logic fs, ws;
        logic [2:0]  sz [3]  = '{3'b101, 3'b001, 3'b100};
        logic [31:0] ad [3]  = '{32'h42, 32'h42, 32'h40};
        logic [31:0] exp [3] = '{32'h0000_8899, 32'hFFFF_8899, 32'h0000_00BB};
        for (int i = 0; i < 3; i++) begin
            do_access(1'b0, sz[i], ad[i], 32'h0, 1'b0, st, wp, wds, ads);
            checks++;
            if (core_rd_o !== exp[i] || st != 2) begin
                failures++;
                $display("FAIL load_ext[%0d]: got %h stall %0d want %h stall 2",
                         i, core_rd_o, st, exp[i]);
            end
            idle_cycle(fs, ws);
        end
    endtask

    task automatic test_store_sub;
        int st, wp;
        logic [31:0] wds, ads;
        logic fs, ws;
        do_access(1'b1, 3'b000, 32'h43, 32'hFFFF_FF5C, 1'b0, st, wp, wds, ads);
        checks++;
        if (wp != 1 || wds !== 32'h5C99_AABB || ads !== 32'h40) begin
            failures++;
            $display("FAIL sb_write: pulses %0d wd %h addr %h want 1 5c99aabb 00000040",
                     wp, wds, ads);
        end
        checks++;
        if (st != 3) begin
            failures++;
            $display("FAIL sb_stall: got %0d want 3", st);
        end
        checks++;
        if (core_rd_o !== 32'h0000_00BB) begin
            failures++;
            $display("FAIL sb_rd_hold: got %h want %h", core_rd_o, 32'h0000_00BB);
        end
        idle_cycle(fs, ws);
        do_access(1'b1, 3'b001, 32'h40, 32'hAAAA_1234, 1'b1, st, wp, wds, ads);
        checks++;
        if (wp != 1 || wds !== 32'h5C99_1234 || st != 3) begin
            failures++;
            $display("FAIL sh_write: pulses %0d wd %h stall %0d want 1 5c991234 3", wp, wds, st);
        end
        idle_cycle(fs, ws);
        do_access(1'b0, 3'b010, 32'h40, 32'h0, 1'b0, st, wp, wds, ads);
        checks++;
        if (core_rd_o !== 32'h5C99_1234) begin
            failures++;
            $display("FAIL sub_readback: got %h want %h", core_rd_o, 32'h5C99_1234);
        end
        idle_cycle(fs, ws);
    endtask

    task automatic test_store_word;
        int st, wp;
        logic [31:0] wds, ads;
        logic fs, ws;
        do_access(1'b1, 3'b010, 32'h10, 32'h1234_5678, 1'b0, st, wp, wds, ads);
        checks++;
        if (wp != 1 || wds !== 32'h1234_5678 || ads !== 32'h10 || st != 2) begin
            failures++;
            $display("FAIL sw_write: pulses %0d wd %h addr %h stall %0d want 1 12345678 10 2",
                     wp, wds, ads, st);
        end
        idle_cycle(fs, ws);
        do_access(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, st, wp, wds, ads);
        checks++;
        if (core_rd_o !== 32'h1234_5678 || st != 2) begin
            failures++;
            $display("FAIL lw_readback: got %h stall %0d want 12345678 2", core_rd_o, st);
        end
        idle_cycle(fs, ws);
    endtask

    task automatic test_faults;
        int st, wp;
        logic [31:0] wds, ads;
        logic fs, ws;
        logic        fwe [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]  fsz [4] = '{3'b010, 3'b001, 3'b000, 3'b011};
        logic [31:0] fad [4] = '{32'h22, 32'h11, 32'h400, 32'h20};
        for (int i = 0; i < 4; i++) begin
            do_access(fwe[i], fsz[i], fad[i], 32'h0BAD_0BAD, 1'b0, st, wp, wds, ads);
            idle_cycle(fs, ws);
            checks++;
            if (st != 0 || wp != 0 || fs !== 1'b1 || ws !== 1'b0) begin
                failures++;
                $display("FAIL fault[%0d]: stall %0d pulses %0d fault %b we %b want 0 0 1 0",
                         i, st, wp, fs, ws);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (fault_o !== 1'b0) begin
            failures++;
            $display("FAIL fault_pulse_width: got %b want 0", fault_o);
        end
    endtask

    task automatic test_back_to_back;
        int st, wp;
        logic [31:0] wds, ads;
        logic fs, ws;
        do_access(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, st, wp, wds, ads);
        do_access(1'b0, 3'b000, 32'h42, 32'h0, 1'b0, st, wp, wds, ads);
        checks++;
        if (core_rd_o !== 32'hFFFF_FF99 || st != 2) begin
            failures++;
            $display("FAIL b2b: got %h stall %0d want ffffff99 2", core_rd_o, st);
        end
        idle_cycle(fs, ws);
    endtask

    task automatic test_reset_mid;
        int wcount;
        int st, wp;
        logic [31:0] wds, ads;
        logic fs, ws;
        @(negedge clk);
        core_req_i  = 1'b1;
        core_we_i   = 1'b1;
        core_size_i = 3'b000;
        core_addr_i = 32'h45;
        core_wd_i   = 32'h0000_00EE;
        @(negedge clk);
        // Now in READ; reset takes effect at the next rising edge.
        rst_n      = 1'b0;
        core_req_i = 1'b0;
        wcount     = 0;
        @(negedge clk);
        #1;
        checks++;
        if (mem_we_o !== 1'b0 || mem_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid: we %b addr %h want 0 0", mem_we_o, mem_addr_o);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            if (mem_we_o) wcount++;
        end
        checks++;
        if (wcount != 0) begin
            failures++;
            $display("FAIL reset_mid_no_write: got %0d pulses want 0", wcount);
        end
        do_access(1'b0, 3'b010, 32'h44, 32'h0, 1'b0, st, wp, wds, ads);
        checks++;
        if (core_rd_o !== 32'h1122_3344) begin
            failures++;
            $display("FAIL reset_mid_mem: got %h want %h", core_rd_o, 32'h1122_3344);
        end
        idle_cycle(fs, ws);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[16] = 32'h8899_AABB;
        mem[17] = 32'h1122_3344;
        test_reset();
        test_load_byte();
        test_load_half();
        test_store_sub();
        test_store_word();
        test_faults();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
